// File: rtl/inst_mem_dump_pkg.sv
// Shared definitions for the memory image dumper: FSM states and default widths
// common with the memory-image loader.
package inst_mem_dump_pkg;

    localparam int unsigned DEF_NUM_OF_BITS      = 16;
    localparam int unsigned DEF_NUM_OF_REGISTERS = 20;
    localparam int unsigned BUF_DEPTH            = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } dump_state_t;

endpackage

// File: rtl/dump_skid_fifo.sv
// Two-entry output buffer for the dump stream. A word arriving while the buffer
// is empty is presented in the same cycle and only stored if it is not taken.
module dump_skid_fifo
    import inst_mem_dump_pkg::*;
#(
    parameter int Num_of_bits = DEF_NUM_OF_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [Num_of_bits-1:0] push_data,
    input  logic                   push_last,
    input  logic                   pop,
    output logic [1:0]             occ,
    output logic                   valid,
    output logic [Num_of_bits-1:0] data,
    output logic                   last
);

    logic [Num_of_bits:0] ent [2];
    logic [Num_of_bits:0] head;
    logic [1:0]           cnt;
    logic                 pop_stored;

    always_comb begin
        head = '0;
        if (cnt != 2'd0)
            head = ent[0];
        else if (push)
            head = {push_last, push_data};
    end

    assign valid      = (cnt != 2'd0) || push;
    assign {last, data} = head;
    assign occ        = cnt;
    assign pop_stored = pop && (cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            ent[0] <= '0;
            ent[1] <= '0;
        end else begin
            assert (!(push && !pop && cnt == 2'd2));
            if (pop_stored) begin
                ent[0] <= ent[1];
                if (push) begin
                    // Refill the slot vacated by the shift; count is unchanged.
                    if (cnt == 2'd1)
                        ent[0] <= {push_last, push_data};
                    else
                        ent[1] <= {push_last, push_data};
                end else begin
                    cnt <= cnt - 2'd1;
                end
            end else if (push && !pop) begin
                if (cnt == 2'd0)
                    ent[0] <= {push_last, push_data};
                else
                    ent[1] <= {push_last, push_data};
                cnt <= cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/inst_mem_dump.sv
// Sweeps an address range of the instruction/data memory over a secondary read
// port and streams the words out in address order on a valid/ready interface.
module inst_mem_dump
    import inst_mem_dump_pkg::*;
#(
    parameter int Num_of_bits      = DEF_NUM_OF_BITS,
    parameter int Num_of_registers = DEF_NUM_OF_REGISTERS,
    parameter int BUF_DEPTH        = inst_mem_dump_pkg::BUF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [Num_of_registers-1:0] base_addr,
    input  logic [Num_of_registers:0]   word_count,
    output logic                        mem_rd_en,
    output logic [Num_of_registers-1:0] mem_addr,
    input  logic [Num_of_bits-1:0]      mem_rd_data,
    output logic [Num_of_bits-1:0]      out_data,
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    localparam logic [Num_of_registers:0] REM_ONE = 1;

    dump_state_t                 state;
    logic [Num_of_registers-1:0] addr;
    logic [Num_of_registers:0]   remaining;
    logic                        inflight;
    logic                        inflight_last;
    logic [1:0]                  occ;
    logic                        pop;
    logic [2:0]                  pending;

    // Words that will sit in the buffer after this edge: a read is only issued
    // when its returning word is guaranteed a free slot.
    assign pop       = out_valid && out_ready;
    assign pending   = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign mem_rd_en = (state == RUN) && (remaining != '0) && (pending < 3'(BUF_DEPTH));
    assign mem_addr  = addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            inflight      <= mem_rd_en;
            inflight_last <= mem_rd_en && (remaining == REM_ONE);
            if (mem_rd_en) begin
                addr      <= addr + Num_of_registers'(1);
                remaining <= remaining - REM_ONE;
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= word_count;
                        busy      <= 1'b1;
                        if (word_count != '0) begin
                            state <= RUN;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (mem_rd_en && (remaining == REM_ONE))
                        state <= FLUSH;
                end
                FLUSH: begin
                    if (pending == 3'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dump_skid_fifo #(
        .Num_of_bits(Num_of_bits)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (mem_rd_data),
        .push_last (inflight_last),
        .pop       (pop),
        .occ       (occ),
        .valid     (out_valid),
        .data      (out_data),
        .last      (out_last)
    );

endmodule

// File: tb/tb_inst_mem_dump.sv
// Scoreboard bench for inst_mem_dump: stimulus queues expected reads and words,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_inst_mem_dump;

    localparam int NB = 16;
    localparam int NR = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NR-1:0] base_addr = '0;
    logic [NR:0]   word_count = '0;
    logic          mem_rd_en;
    logic [NR-1:0] mem_addr;
    logic [NB-1:0] mem_rd_data = '0;
    logic [NB-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;

    int            checks = 0;
    int            errors = 0;
    int            pop_count = 0;
    int            done_count = 0;
    int            ready_mode = 0;
    logic [NB:0]   exp_q[$];
    logic [NR-1:0] exp_addr_q[$];

    always #5 clk = ~clk;

    inst_mem_dump #(
        .Num_of_bits      (NB),
        .Num_of_registers (NR),
        .BUF_DEPTH        (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    // Preloaded memory contents: mem[i] = i ^ 16'hA5A5.
    function automatic logic [NB-1:0] mem_word(input logic [NR-1:0] a);
        return a[NB-1:0] ^ 16'hA5A5;
    endfunction

    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= mem_word(mem_addr);

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        if (act !== req) fail(name, act, req);
        else checks++;
    endtask

    // Downstream readiness: 0 = always ready, 1 = random, 2 = pattern 1,0,0,...
    initial begin
        int unsigned pat = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (pat % 3 == 0);
            endcase
            pat++;
        end
    end

    // Monitor: compares reads and stream words against the scoreboard queues.
    initial begin
        logic        prev_stall;
        logic [NB:0] prev_word;
        logic [NB:0] exp_w;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (mem_rd_en) begin
                    if (exp_addr_q.size() == 0) fail("unexpected_read", mem_addr, 0);
                    else check("read_addr", mem_addr, exp_addr_q.pop_front());
                end
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_word", {out_last, out_data}, prev_word);
                end
                if (out_valid && out_ready) begin
                    pop_count++;
                    if (exp_q.size() == 0) begin
                        fail("unexpected_word", {out_last, out_data}, 0);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("stream_word", {out_last, out_data}, exp_w);
                    end
                end
                if (done) done_count++;
                prev_stall = out_valid && !out_ready;
                prev_word  = {out_last, out_data};
            end
        end
    end

    task automatic expect_dump(input logic [NR-1:0] base, input int unsigned count);
        for (int unsigned i = 0; i < count; i++) begin
            logic [NR-1:0] a;
            a = base + NR'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back({(i == count - 1), mem_word(a)});
        end
    endtask

    task automatic issue_start(input logic [NR-1:0] base, input int unsigned count);
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = base;
        word_count = (NR+1)'(count);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_dump(input logic [NR-1:0] base, input int unsigned count,
                            input int mode, input bit timed, input bit poke);
        int unsigned cycles;
        bit          seen;
        int          done_before;
        cycles      = 0;
        seen        = 1'b0;
        done_before = done_count;
        expect_dump(base, count);
        ready_mode = mode;
        issue_start(base, count);
        while (!seen && cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1 && count != 0) check("busy_running", busy, 1);
            if (poke && cycles == 3) begin
                start      = 1'b1;
                base_addr  = 20'h55555;
                word_count = 21'd7;
            end
            if (poke && cycles == 4) start = 1'b0;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            fail("done_timeout", cycles, 0);
        end else begin
            if (timed) check("done_latency", cycles, (count == 0) ? 1 : count + 2);
            if (count != 0) check("busy_at_done", busy, 0);
            check("words_left", exp_q.size(), 0);
            check("reads_left", exp_addr_q.size(), 0);
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        repeat (3) @(negedge clk);
        check("done_pulses", done_count - done_before, 1);
    endtask

    initial begin
        int unsigned cycles;
        int          target;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, done}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed scenarios
        run_dump(20'h00010, 4, 0, 1'b1, 1'b0);
        run_dump(20'h00010, 4, 2, 1'b0, 1'b0);
        run_dump(20'hFFFFF, 3, 0, 1'b1, 1'b0);
        run_dump(20'h00123, 0, 0, 1'b1, 1'b0);

        // Reset in the middle of an 8-word dump
        expect_dump(20'h00400, 8);
        ready_mode = 0;
        target     = pop_count + 2;
        issue_start(20'h00400, 8);
        cycles = 0;
        while (pop_count < target && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        if (pop_count < target) fail("reset_wait_timeout", pop_count, target);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        check("midreset_outputs", {mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, done}, 0);
        @(negedge clk);
        check("late_response_dropped", out_valid, 0);
        run_dump(20'h00000, 1, 0, 1'b1, 1'b0);

        // start while busy is ignored
        run_dump(20'h00200, 6, 1, 1'b0, 1'b1);

        // Randomized dumps, some across the top of the address space
        for (int k = 0; k < 12; k++) begin
            logic [NR-1:0] b;
            int unsigned   n;
            int            m;
            b = (k % 3 == 0) ? 20'hFFFFF - NR'($urandom_range(0, 5)) : NR'($urandom);
            n = $urandom_range(1, 10);
            m = $urandom_range(0, 1);
            run_dump(b, n, m, (m == 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
